uart_frame_parser: RTL
======================

# uart_frame_parser

Byte-stream framer sitting directly downstream of the UART receiver: consumes its one-cycle `dataValid`/`dataOut` byte strobes and assembles framed command packets (sync, command, length, payload, XOR checksum). Validated frames are buffered and presented to the command decoder through a valid/ready handshake. Malformed, truncated or overrun frames are dropped and reported with a one-cycle error pulse.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker
- `MAX_LEN`, 16, maximum payload bytes (1..255)
- `TIMEOUT_CYCLES`, 50000, inter-byte timeout inside a frame, in clk cycles (≥2)

- `clk` in 1: the single clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `rxData` in 8: received byte, from receiver `dataOut`.
- `rxValid` in 1: one-cycle byte strobe, from receiver `dataValid`.
- `frameValid` out 1: a frame is held on the outputs.
- `frameReady` in 1: consumer accepts the frame.
- `frameCmd` out 8: command byte.
- `frameLen` out 8: payload length (0..MAX_LEN).
- `framePayload` out 8*MAX_LEN: byte i at `[8*i +: 8]`; bytes at index ≥ `frameLen` are zero.
- `errValid` out 1: one-cycle error pulse.
- `errCode` out 2: 0 LEN, 1 CSUM, 2 TIMEOUT, 3 OVERRUN; valid only with `errValid`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CHK. CHK = CMD ^ LEN ^ all payload bytes.
- States: IDLE, CMD, LEN, PAYLOAD, CHECK, HOLD. Each state below advances only on a cycle where `rxValid`=1.
- IDLE:
  - `rxData`==SYNC_BYTE → CMD.
  - Any other byte is ignored, with no error.
- CMD: latch the command byte, seed the running XOR with it → LEN.
- LEN:
  - LEN > MAX_LEN → error LEN, go to IDLE.
  - LEN = 0 → CHECK.
  - Otherwise → PAYLOAD.
  - In all cases the running XOR absorbs LEN.
- PAYLOAD:
  - Store the byte at the current index, XOR it into the running checksum, increment the index.
  - After the LEN-th byte → CHECK.
- CHECK:
  - Byte == running XOR → HOLD, `frameValid`=1.
  - Otherwise → error CSUM, go to IDLE.
- HOLD:
  - Outputs stay stable until a cycle with `frameValid`&&`frameReady`, then go to IDLE.
  - Any `rxValid` while in HOLD, including the handshake cycle, discards the byte and raises error OVERRUN. The held frame is unaffected.
- The payload buffer and index are cleared on entry to CMD, so unused bytes read as zero.
- Timeout:
  - The counter resets on every accepted byte and on entry to CMD. It counts cycles while in CMD, LEN, PAYLOAD or CHECK.
  - If it reaches TIMEOUT_CYCLES-1 with no `rxValid` → error TIMEOUT, go to IDLE.
  - `rxValid` in the expiry cycle wins: the byte is processed and no timeout fires.
  - The counter is inactive in IDLE and HOLD.
- A SYNC_BYTE value received mid-frame is ordinary data; there is no resync.
- Only one error can occur per cycle. Error pulses never coincide with a `frameValid` rising edge.

## Timing
- Reset values:
  - `frameValid`=0, `frameCmd`=0, `frameLen`=0, `framePayload`=0.
  - `errValid`=0, `errCode`=0, `busy`=0.
  - State = IDLE, counters = 0.
- Asserting `resetn` mid-frame or in HOLD aborts immediately. No error is reported and the frame is lost.
- All outputs are registered.
- `frameValid` rises the cycle after the `rxValid` cycle carrying a correct CHK.
- `frameValid` falls the cycle after the handshake. The earliest next SYNC is accepted the cycle after that.
- `errValid` is high for exactly the one cycle after the triggering byte or the timeout expiry cycle.
- `busy` is registered from the state.
- Back-to-back `rxValid` on consecutive cycles must be handled; the parser has no throughput limit.

## Test plan
- Good frame, no stall: A5, 10, 03, 11, 22, 33, CHK=0x10^0x03^0x11^0x22^0x33=0x13, `frameReady`=1 → `frameValid` for 1 cycle, `frameCmd`=0x10, `frameLen`=3, payload bytes 0..2 = 11,22,33, rest zero, no error.
- Zero length plus leading garbage: 00, 7F, A5, 42, 00, CHK=0x42 → frame with cmd 0x42, len 0, no error (leading bytes ignored).
- Bad checksum and bad length:
  - A5, 10, 01, 55, CHK=00 → `errValid`, `errCode`=1, no frame.
  - A5, 10, LEN=MAX_LEN+1 → `errCode`=0, then IDLE.
- Timeout: A5, 10, 02, 01, then silence → `errCode`=2 exactly TIMEOUT_CYCLES cycles after the 01 strobe, `busy` drops.
  - Repeat with a byte arriving in the expiry cycle → no error.
- Backpressure/overrun: complete a frame with `frameReady`=0, send 2 bytes → 2 OVERRUN pulses, frame outputs unchanged.
  - Then raise `frameReady` → frame accepted.
  - Next valid frame parses correctly.
- Reset mid-frame: assert `resetn`=0 during PAYLOAD → all outputs zero, no error.
  - After release, a full good frame parses correctly.

Source files
------------

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: assembles sync/cmd/len/payload/xor-checked frames from UART byte strobes and hands them off via valid/ready
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [7:0]           rxData,
  input  logic                 rxValid,
  output logic                 frameValid,
  input  logic                 frameReady,
  output logic [7:0]           frameCmd,
  output logic [7:0]           frameLen,
  output logic [8*MAX_LEN-1:0] framePayload,
  output logic                 errValid,
  output logic [1:0]           errCode,
  output logic                 busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, CMD, LEN, PAYLOAD, CHECK, HOLD} state_t;
  state_t state, nextState;
  logic [7:0] idx, csum;
  logic [TW-1:0] timer;
  logic errNext, timeout;
  logic [1:0] codeNext;
  assign timeout = (state inside {CMD, LEN, PAYLOAD, CHECK}) && !rxValid && timer == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    nextState = state;
    errNext = 1'b0;
    codeNext = 2'd0;
    case (state)
      IDLE: if (rxValid && rxData == SYNC_BYTE) nextState = CMD;
      CMD: if (rxValid) nextState = LEN;
      LEN: if (rxValid) begin
        errNext = rxData > 8'(MAX_LEN);
        nextState = errNext ? IDLE : rxData == 8'd0 ? CHECK : PAYLOAD;
      end
      PAYLOAD: if (rxValid && idx == frameLen - 8'd1) nextState = CHECK;
      CHECK: if (rxValid) begin
        errNext = rxData != csum;
        codeNext = 2'd1;
        nextState = errNext ? IDLE : HOLD;
      end
      HOLD: begin
        if (frameValid && frameReady) nextState = IDLE;
        errNext = rxValid;
        codeNext = 2'd3;
      end
      default: nextState = IDLE;
    endcase
    if (timeout) begin
      nextState = IDLE;
      errNext = 1'b1;
      codeNext = 2'd2;
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      frameValid <= 1'b0;
      frameCmd <= '0;
      frameLen <= '0;
      framePayload <= '0;
      errValid <= 1'b0;
      errCode <= '0;
      busy <= 1'b0;
      idx <= '0;
      csum <= '0;
      timer <= '0;
    end else begin
      state <= nextState;
      frameValid <= nextState == HOLD;
      busy <= nextState != IDLE;
      errValid <= errNext;
      if (errNext) errCode <= codeNext;
      timer <= (rxValid || state == IDLE || state == HOLD) ? '0 : timer + 1'b1;
      if (rxValid)
        case (state)
          IDLE: if (rxData == SYNC_BYTE) begin
            framePayload <= '0;
            idx <= '0;
          end
          CMD: begin
            frameCmd <= rxData;
            csum <= rxData;
          end
          LEN: begin
            csum <= csum ^ rxData;
            if (rxData <= 8'(MAX_LEN)) frameLen <= rxData;
          end
          PAYLOAD: begin
            csum <= csum ^ rxData;
            idx <= idx + 8'd1;
            for (int i = 0; i < MAX_LEN; i++) if (idx == 8'(i)) framePayload[8*i +: 8] <= rxData;
          end
          default: ;
        endcase
    end
endmodule
